// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array and its operand feed sequencer.
package systolic_array_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sa_ctrl_state_t;

endpackage

// File: rtl/sa_skew_buffer.sv
// N x N operand bank for X and W with a slot write port and a combinational
// diagonally-skewed read that zero-pads lanes outside the current wavefront.
module sa_skew_buffer
    import systolic_array_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N + 1),
    parameter int TW = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [SW-1:0]   wr_slot,
    input  word_t [N-1:0]   wr_x,
    input  word_t [N-1:0]   wr_w,
    input  logic [TW-1:0]   rd_t,
    output word_t [N-1:0]   rd_x,
    output word_t [N-1:0]   rd_w
);

    word_t [N-1:0] x_bank_r [N];
    word_t [N-1:0] w_bank_r [N];

    // Bank write: one beat per accepted handshake; contents need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (wr_en && (int'(wr_slot) == k)) begin
                x_bank_r[k] <= wr_x;
                w_bank_r[k] <= wr_w;
            end
        end
    end

    // Skewed read: lane i carries beat t-i; at most one beat matches each lane.
    always_comb begin
        rd_x = '0;
        rd_w = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                rd_x[i] = rd_x[i] | ((int'(rd_t) == (k + i)) ? x_bank_r[k][i] : 32'h0000_0000);
                rd_w[i] = rd_w[i] | ((int'(rd_t) == (k + i)) ? w_bank_r[k][i] : 32'h0000_0000);
            end
        end
    end

endmodule

// File: rtl/sa_feed_ctrl.sv
// Loads N operand beats, then feeds them into the systolic array with diagonal
// skew, honouring stall, and pulses done once the drain interval has elapsed.
module sa_feed_ctrl
    import systolic_array_pkg::*;
#(
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = N
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  word_t [N-1:0]   ld_x,
    input  word_t [N-1:0]   ld_w,
    input  logic            go,
    output logic            busy,
    output logic            done,
    output logic            sa_start,
    output word_t [N-1:0]   sa_x_in,
    output word_t [N-1:0]   sa_w_in,
    input  logic            sa_stall
);

    localparam int TW = $clog2(2 * N);
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [TW-1:0] T_LAST     = TW'(2 * N - 2);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(N - 1);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    sa_ctrl_state_t state_r, state_nxt_s;
    logic [BW-1:0]  cnt_r, cnt_nxt_s;
    logic [TW-1:0]  t_r, t_nxt_s;
    logic [DW-1:0]  drain_r, drain_nxt_s;
    logic           wr_en_s;
    word_t [N-1:0]  rd_x_s, rd_w_s;

    logic           ld_ready_r, busy_r, done_r, sa_start_r;
    word_t [N-1:0]  sa_x_in_r, sa_w_in_r;

    sa_skew_buffer #(.N(N), .SW(BW), .TW(TW)) u_skew (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_slot (cnt_r),
        .wr_x    (ld_x),
        .wr_w    (ld_w),
        .rd_t    (t_nxt_s),
        .rd_x    (rd_x_s),
        .rd_w    (rd_w_s)
    );

    // Next-state and counter logic; stalls freeze both t and the drain count.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        t_nxt_s     = t_r;
        drain_nxt_s = drain_r;
        wr_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ld_valid && ld_ready_r) begin
                    wr_en_s   = 1'b1;
                    cnt_nxt_s = cnt_r + BEAT_ONE;
                    if (cnt_r == BEAT_LAST) begin
                        state_nxt_s = LOADED;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            LOADED: begin
                if (go) begin
                    state_nxt_s = FEED;
                    t_nxt_s     = '0;
                end else begin
                    state_nxt_s = LOADED;
                end
            end
            FEED: begin
                if (!sa_stall) begin
                    if (t_r == T_LAST) begin
                        state_nxt_s = DRAIN;
                        drain_nxt_s = '0;
                    end else begin
                        t_nxt_s = t_r + T_ONE;
                    end
                end else begin
                    state_nxt_s = FEED;
                end
            end
            DRAIN: begin
                if (!sa_stall) begin
                    if (drain_r == DRAIN_LAST) begin
                        state_nxt_s = DONE;
                    end else begin
                        drain_nxt_s = drain_r + DRAIN_ONE;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                t_nxt_s     = '0;
                drain_nxt_s = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            t_r     <= '0;
            drain_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            t_r     <= t_nxt_s;
            drain_r <= drain_nxt_s;
        end
    end

    // Output registers decoded from the next state so they align with state_r.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ld_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            sa_start_r <= 1'b0;
            done_r     <= 1'b0;
            sa_x_in_r  <= '0;
            sa_w_in_r  <= '0;
        end else begin
            ld_ready_r <= (state_nxt_s == IDLE);
            busy_r     <= (state_nxt_s == FEED) || (state_nxt_s == DRAIN);
            sa_start_r <= (state_nxt_s == FEED) || (state_nxt_s == DRAIN);
            done_r     <= (state_nxt_s == DONE);
            sa_x_in_r  <= (state_nxt_s == FEED) ? rd_x_s : '0;
            sa_w_in_r  <= (state_nxt_s == FEED) ? rd_w_s : '0;
        end
    end

    assign ld_ready = ld_ready_r;
    assign busy     = busy_r;
    assign sa_start = sa_start_r;
    assign done     = done_r;
    assign sa_x_in  = sa_x_in_r;
    assign sa_w_in  = sa_w_in_r;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Randomized bench for sa_feed_ctrl: an expected per-cycle timeline is built
// from the operand matrices and the stall pattern, then compared cycle by cycle.
module tb_sa_feed_ctrl;
    import systolic_array_pkg::*;

    localparam int N  = 4;
    localparam int DC = N;

    typedef word_t [N-1:0] vec_t;
    typedef struct {
        bit stall;
        bit busy;
        bit done;
        bit rdy;
        int t;
    } ent_t;

    logic clk      = 1'b0;
    logic n_rst    = 1'b1;
    logic ld_valid = 1'b0;
    logic go       = 1'b0;
    logic sa_stall = 1'b0;
    vec_t ld_x     = '0;
    vec_t ld_w     = '0;
    logic ld_ready, busy, done, sa_start;
    vec_t sa_x_in, sa_w_in;

    int   total = 0;
    int   bad   = 0;

    word_t mx [N][N];
    word_t mw [N][N];
    vec_t  obs_x [2*N-1];
    vec_t  obs_w [2*N-1];
    ent_t  tl [$];

    always #5 clk = ~clk;

    sa_feed_ctrl #(.N(N), .DRAIN_CYCLES(DC)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_x     (ld_x),
        .ld_w     (ld_w),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .sa_start (sa_start),
        .sa_x_in  (sa_x_in),
        .sa_w_in  (sa_w_in),
        .sa_stall (sa_stall)
    );

    // Wavefront t puts beat t-i on lane i; outside the matrix the lane is zero.
    function automatic vec_t exp_x(input int t);
        vec_t v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i] = mx[t-i][i];
        return v;
    endfunction

    function automatic vec_t exp_w(input int t);
        vec_t v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j] = mw[t-j][j];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beats(input int first, input int count, input bit pattern);
        for (int k = first; k < first + count; k++) begin
            vec_t vx, vw;
            int   guard;
            for (int i = 0; i < N; i++) begin
                vx[i] = pattern ? word_t'(16 * k + i) : $urandom();
                vw[i] = pattern ? word_t'(16 * k + i) : $urandom();
            end
            if (!pattern && $urandom_range(0, 1) == 1) begin
                ld_valid = 1'b0;
                step();
            end
            ld_x = vx;
            ld_w = vw;
            ld_valid = 1'b1;
            guard = 0;
            while (ld_ready !== 1'b1 && guard < 20) begin
                step();
                guard++;
            end
            total++;
            if (guard == 20) begin
                $display("FAIL load_wait beat=%0d ld_ready got=%b exp=1", k, ld_ready);
                bad++;
            end
            step();
            for (int i = 0; i < N; i++) begin
                mx[k][i] = vx[i];
                mw[k][i] = vw[i];
            end
        end
        ld_valid = 1'b0;
    endtask

    // mode 0: no stall, 1: three stall cycles at t=3, 2: random stalls in FEED and DRAIN
    task automatic build_timeline(input int mode);
        int s;
        tl.delete();
        for (int t = 0; t <= 2 * N - 2; t++) begin
            s = (mode == 1 && t == 3) ? 3 : (mode == 2 ? $urandom_range(0, 3) / 2 : 0);
            for (int q = 0; q < s; q++) tl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, t});
            tl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, t});
        end
        for (int d = 0; d < DC; d++) begin
            s = (mode == 2) ? $urandom_range(0, 2) / 2 : 0;
            for (int q = 0; q < s; q++) tl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, -1});
            tl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, -1});
        end
        tl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, -1});
        tl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, -1});
    endtask

    // Expects the DUT in LOADED; issues go and checks every cycle until back in IDLE.
    task automatic test_operation(input string name, input int mode, input bit extra_go, input bit junk_ld);
        int dones = 0;
        build_timeline(mode);
        go = 1'b1;
        ld_valid = junk_ld;
        ld_x = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        total++;
        if (ld_ready !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s loaded ld_ready/busy got=%b%b exp=00", name, ld_ready, busy);
            bad++;
        end
        step();
        for (int idx = 0; idx < tl.size(); idx++) begin
            ent_t e = tl[idx];
            sa_stall = e.stall;
            go       = extra_go && (idx < tl.size() - 1);
            ld_valid = junk_ld && (idx < tl.size() - 1);
            ld_x     = {$urandom(), $urandom(), $urandom(), $urandom()};
            ld_w     = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            total++;
            if (busy !== e.busy) begin
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, idx, busy, e.busy);
                bad++;
            end
            total++;
            if (sa_start !== e.busy) begin
                $display("FAIL %s sa_start cyc=%0d got=%b exp=%b", name, idx, sa_start, e.busy);
                bad++;
            end
            total++;
            if (done !== e.done) begin
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, idx, done, e.done);
                bad++;
            end
            total++;
            if (ld_ready !== e.rdy) begin
                $display("FAIL %s ld_ready cyc=%0d got=%b exp=%b", name, idx, ld_ready, e.rdy);
                bad++;
            end
            total++;
            if (sa_x_in !== exp_x(e.t)) begin
                $display("FAIL %s sa_x_in cyc=%0d t=%0d got=%h exp=%h", name, idx, e.t, sa_x_in, exp_x(e.t));
                bad++;
            end
            total++;
            if (sa_w_in !== exp_w(e.t)) begin
                $display("FAIL %s sa_w_in cyc=%0d t=%0d got=%h exp=%h", name, idx, e.t, sa_w_in, exp_w(e.t));
                bad++;
            end
            if (e.t >= 0) begin
                obs_x[e.t] = sa_x_in;
                obs_w[e.t] = sa_w_in;
            end
            if (done === 1'b1) dones++;
            step();
        end
        sa_stall = 1'b0;
        go = 1'b0;
        ld_valid = 1'b0;
        total++;
        if (dones != 1) begin
            $display("FAIL %s done_count got=%0d exp=1", name, dones);
            bad++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({ld_ready, busy, done, sa_start} !== 4'b0000 || sa_x_in !== '0 || sa_w_in !== '0) begin
            $display("FAIL reset_hold outputs got=%b%b%b%b x=%h w=%h exp=0", ld_ready, busy, done, sa_start, sa_x_in, sa_w_in);
            bad++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({ld_ready, busy, done} !== 3'b100) begin
            $display("FAIL reset_release ld_ready/busy/done got=%b%b%b exp=100", ld_ready, busy, done);
            bad++;
        end
        step();
    endtask

    task automatic test_skew();
        vec_t e0, e3, e6;
        load_beats(0, N, 1'b1);
        test_operation("skew", 0, 1'b0, 1'b0);
        e0 = '0;
        e3 = {32'h0000_0003, 32'h0000_0012, 32'h0000_0021, 32'h0000_0030};
        e6 = {32'h0000_0033, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        total++;
        if (obs_x[0] !== e0 || obs_w[0] !== e0) begin
            $display("FAIL skew_t0 got x=%h w=%h exp=%h", obs_x[0], obs_w[0], e0);
            bad++;
        end
        total++;
        if (obs_x[3] !== e3 || obs_w[3] !== e3) begin
            $display("FAIL skew_t3 got x=%h w=%h exp=%h", obs_x[3], obs_w[3], e3);
            bad++;
        end
        total++;
        if (obs_x[6] !== e6 || obs_w[6] !== e6) begin
            $display("FAIL skew_t6 got x=%h w=%h exp=%h", obs_x[6], obs_w[6], e6);
            bad++;
        end
    endtask

    task automatic test_stall();
        load_beats(0, N, 1'b0);
        test_operation("stall_t3", 1, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_controls();
        int bad_cycles = 0;
        load_beats(0, 2, 1'b0);
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ld_ready !== 1'b1) bad_cycles++;
            step();
        end
        total++;
        if (bad_cycles != 0) begin
            $display("FAIL go_in_idle busy/ld_ready bad_cycles got=%0d exp=0", bad_cycles);
            bad++;
        end
        load_beats(2, 2, 1'b0);
        test_operation("ignored_ctrl", 0, 1'b1, 1'b1);
        go = 1'b1;
        load_beats(0, N, 1'b0);
        test_operation("go_held", 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_feed();
        int seen_done = 0;
        load_beats(0, N, 1'b0);
        go = 1'b1;
        step();
        go = 1'b0;
        repeat (4) step();
        total++;
        if (busy !== 1'b1 || sa_x_in !== exp_x(4)) begin
            $display("FAIL pre_abort busy/x got=%b %h exp=1 %h", busy, sa_x_in, exp_x(4));
            bad++;
        end
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({ld_ready, busy, done, sa_start} !== 4'b0000 || sa_x_in !== '0 || sa_w_in !== '0) begin
            $display("FAIL abort_outputs got=%b%b%b%b x=%h w=%h exp=0", ld_ready, busy, done, sa_start, sa_x_in, sa_w_in);
            bad++;
        end
        @(negedge clk);
        n_rst = 1'b1;
        step();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) seen_done++;
            step();
        end
        total++;
        if (seen_done != 0 || ld_ready !== 1'b1) begin
            $display("FAIL abort_idle done/busy cycles got=%0d ld_ready=%b exp=0 1", seen_done, ld_ready);
            bad++;
        end
        load_beats(0, N, 1'b0);
        test_operation("after_abort", 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            load_beats(0, N, 1'b0);
            test_operation("random", 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_stall();
        test_ignored_controls();
        test_reset_mid_feed();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
